// File: rtl/p2s_frame_sched.sv
// p2s_frame_sched: serialises NUM_CH pooled-feature streams onto one output
// bus in interleaved (pixel-major) or planar (channel-major) order, framed by
// start/done/abort, with valid/ready backpressure on every channel.
module p2s_frame_sched #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 3,
  parameter int PIX_PER_CH = 169,
  parameter int CH_W       = $clog2(NUM_CH),
  parameter int PIX_W      = $clog2(PIX_PER_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     abort,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic [NUM_CH-1:0]        s_valid,
  output logic [NUM_CH-1:0]        s_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [CH_W-1:0]          m_ch,
  output logic                     m_first,
  output logic                     m_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                          state, state_nxt;
  logic                            mode_q;
  logic                            first_pend;
  logic [CH_W-1:0]                 ch_cur;
  logic [PIX_W-1:0]                pix_cnt;
  logic [NUM_CH-1:0][DATA_W-1:0]   lane_data;
  logic [NUM_CH-1:0]               lane_sel;
  logic [DATA_W-1:0]               sel_data;
  logic                            out_free;
  logic                            xfer;
  logic                            ch_last;
  logic                            pix_last;
  logic                            last_xfer;
  logic                            start_ok;
  logic                            drain_ack;

  // Flat input bus viewed as one lane per channel (same bit layout).
  assign lane_data = s_data;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign lane_sel[c] = (ch_cur == CH_W'(c));
  end

  // Output register can take a new beat if empty or being drained this cycle.
  assign out_free  = !m_valid || m_ready;
  // Abort wins over a handshake: the beat offered in an abort cycle is dropped.
  assign xfer      = (|(s_valid & s_ready)) && !abort;
  assign ch_last   = (ch_cur  == CH_W'(NUM_CH - 1));
  assign pix_last  = (pix_cnt == PIX_W'(PIX_PER_CH - 1));
  // Final beat is always (last channel, last pixel) in both orders.
  assign last_xfer = xfer && ch_last && pix_last;
  // The done cycle is already IDLE but still belongs to the finishing frame.
  assign start_ok  = (state == IDLE) && start && !done && !abort;
  assign drain_ack = (state == DRAIN) && m_valid && m_ready && !abort;

  // Selected channel's sample for loading the output register.
  always_comb begin
    sel_data = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (lane_sel[c]) sel_data = lane_data[c];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic; abort forces IDLE from any state.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok)           state_nxt = RUN;
        RUN:     if (last_xfer)          state_nxt = DRAIN;
        DRAIN:   if (m_valid && m_ready) state_nxt = IDLE;
        default:                         state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: ready only to the granted channel, never looks at s_valid.
  always_comb begin
    s_ready = '0;
    if (state == RUN && out_free) s_ready = lane_sel;
    busy = (state != IDLE);
  end

  // Frame counters: channel/pixel position and the first-beat marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 1'b0;
      first_pend <= 1'b0;
      ch_cur     <= '0;
      pix_cnt    <= '0;
    end else if (abort) begin
      first_pend <= 1'b0;
      ch_cur     <= '0;
      pix_cnt    <= '0;
    end else if (start_ok) begin
      mode_q     <= mode;
      first_pend <= 1'b1;
      ch_cur     <= '0;
      pix_cnt    <= '0;
    end else if (xfer) begin
      first_pend <= 1'b0;
      if (!mode_q) begin
        ch_cur <= ch_last ? '0 : ch_cur + CH_W'(1);
        if (ch_last) pix_cnt <= pix_last ? '0 : pix_cnt + PIX_W'(1);
      end else begin
        pix_cnt <= pix_last ? '0 : pix_cnt + PIX_W'(1);
        if (pix_last) ch_cur <= ch_last ? '0 : ch_cur + CH_W'(1);
      end
    end
  end

  // Output beat register: load on transfer, hold while stalled, empty on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_ch    <= '0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (abort) begin
      m_valid <= 1'b0;
    end else if (xfer) begin
      m_data  <= sel_data;
      m_ch    <= ch_cur;
      m_first <= first_pend;
      m_last  <= ch_last && pix_last;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // One-cycle completion pulse after the last beat leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= drain_ack;
  end

endmodule

// File: tb/tb_p2s_frame_sched.sv
// Directed bench for p2s_frame_sched with NUM_CH=3, PIX_PER_CH=4.
// Channel c sample p carries the value 16*c+p.
module tb_p2s_frame_sched;
  localparam int NC = 3;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b1;
  logic [NC*DW-1:0] s_data;
  logic [NC-1:0] s_valid;
  logic [NC-1:0] s_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_ch;
  logic          m_first, m_last, m_valid, busy, done;

  always #5 clk = ~clk;

  p2s_frame_sched #(.DATA_W(DW), .NUM_CH(NC), .PIX_PER_CH(NP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_ch(m_ch), .m_first(m_first), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  int          ptr [NC];
  logic [NC-1:0] en = '1;
  int          cyc, xfer_cnt, done_cnt, done_cyc, last_cyc, gap_left;
  bit          mr_pat, gap_req, gap_used, plan_watch, sod, idle_watch;
  bit          hold_bad, plan_bad, gap_bad, busy_bad, idle_bad;
  bit          held_v;
  logic [11:0] held;
  logic [11:0] beats[$];

  int exp_il[12] = '{0, 16, 32, 1, 17, 33, 2, 18, 34, 3, 19, 35};
  int exp_pl[12] = '{0, 1, 2, 3, 16, 17, 18, 19, 32, 33, 34, 35};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_src();
    for (int c = 0; c < NC; c++) begin
      s_data[c*DW +: DW] = DW'(16*c + ptr[c]);
      s_valid[c]         = en[c] && (ptr[c] < NP);
    end
  endtask

  // One clock: sample at negedge, then update sources after posedge.
  task automatic step();
    logic [11:0]   cur;
    logic [NC-1:0] acc;
    @(negedge clk);
    cur = {m_first, m_last, m_ch, m_data};
    if (held_v && m_valid && cur !== held) hold_bad = 1;
    held_v = m_valid && !m_ready;
    held   = cur;
    if (m_valid && m_ready) begin
      beats.push_back(cur);
      if (m_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) busy_bad = 1;
      if (sod) start = 1'b1;
    end
    if (plan_watch && xfer_cnt < 4 && s_ready[2:1] != 2'b00) plan_bad = 1;
    if (gap_left > 0) begin
      if (s_ready[0] || s_ready[2] || (s_valid & s_ready) != '0) gap_bad = 1;
      gap_left--;
    end
    if (idle_watch && s_ready != '0) idle_bad = 1;
    acc = s_valid & s_ready;
    if (acc != '0) xfer_cnt++;
    @(posedge clk);
    #1;
    if (sod && start) begin start = 1'b0; sod = 0; end
    for (int c = 0; c < NC; c++) if (acc[c]) ptr[c]++;
    cyc++;
    m_ready = mr_pat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    if (gap_req && !gap_used && xfer_cnt == 4) begin gap_left = 10; gap_used = 1; end
    en[1] = (gap_left == 0);
    drive_src();
  endtask

  task automatic init_frame(input logic md, input bit mrp, input bit gr, input bit pw);
    beats.delete();
    xfer_cnt = 0; done_cnt = 0; done_cyc = -100; last_cyc = -100; gap_left = 0;
    mr_pat = mrp; gap_req = gr; gap_used = 0; plan_watch = pw; sod = 0; idle_watch = 0;
    hold_bad = 0; plan_bad = 0; gap_bad = 0; busy_bad = 0; idle_bad = 0; held_v = 0;
    for (int c = 0; c < NC; c++) ptr[c] = 0;
    en = '1;
    m_ready = 1'b1;
    drive_src();
    mode  = md;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && done_cnt == 0; i++) step();
    step();
    step();
  endtask

  task automatic check_frame(input string tag, input int tab[12]);
    logic [7:0]  d;
    logic [11:0] e;
    chk($sformatf("%s_nbeats", tag), beats.size(), 12);
    for (int i = 0; i < 12; i++) begin
      d = 8'(tab[i]);
      e = {(i == 0), (i == 11), d[5:4], d};
      if (i < beats.size()) chk($sformatf("%s_beat%0d", tag, i), beats[i], e);
    end
    chk($sformatf("%s_done_cnt", tag), done_cnt, 1);
    chk($sformatf("%s_done_timing", tag), done_cyc, last_cyc + 1);
    chk($sformatf("%s_busy_at_done", tag), busy_bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < NC; c++) ptr[c] = 0;
    drive_src();
    #2 rst_n = 1'b0;
    #10;
    chk("reset_outputs", {m_data, m_ch, m_first, m_last, m_valid, done, busy, s_ready}, 0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_sready", s_ready, 0);

    // Interleaved frame; a start during the done cycle must be ignored.
    init_frame(1'b0, 0, 0, 0);
    sod = 1;
    wait_done();
    check_frame("il", exp_il);
    chk("start_on_done_busy", busy, 0);
    chk("start_on_done_sready", s_ready, 0);

    // Planar frame; ch1/ch2 never granted during ch0's pixels.
    init_frame(1'b1, 0, 0, 1);
    wait_done();
    check_frame("pl", exp_pl);
    chk("pl_sready_ch12", plan_bad, 0);

    // Downstream backpressure 1,0,0,1.
    init_frame(1'b0, 1, 0, 0);
    wait_done();
    check_frame("bp", exp_il);
    chk("bp_hold_stable", hold_bad, 0);

    // ch1 starved for 10 cycles mid-frame.
    init_frame(1'b0, 0, 1, 0);
    wait_done();
    check_frame("gap", exp_il);
    chk("gap_happened", gap_used, 1);
    chk("gap_no_grant", gap_bad, 0);

    // Abort together with start after 5 beats.
    init_frame(1'b0, 0, 0, 0);
    for (int i = 0; i < 50 && xfer_cnt < 5; i++) step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_idle", {m_valid, busy, done, s_ready}, 0);
    step(); step(); step();
    chk("abort_no_done", done_cnt, 0);
    init_frame(1'b0, 0, 0, 0);
    wait_done();
    check_frame("post_abort", exp_il);

    // Asynchronous reset mid-frame.
    init_frame(1'b0, 0, 0, 0);
    for (int i = 0; i < 50 && xfer_cnt < 6; i++) step();
    chk("midrst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {m_data, m_ch, m_first, m_last, m_valid, done, busy, s_ready}, 0);
    #3 rst_n = 1'b1;
    idle_watch = 1;
    step(); step(); step(); step();
    chk("midrst_no_sready", idle_bad, 0);
    chk("midrst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
